// File: rtl/m31_partial_round_seq.sv
// m31_partial_round_seq: iterated partial round over GF(2^31-1).
// Ports: clk, rst_n, in_valid_i/in_ready_o/state_i, rc_idx_o/rc_i,
//   out_valid_o/out_ready_i/state_o. One state in flight at a time.

package m31_pkg;

  typedef logic [30:0] m31_t;

  localparam m31_t P_M31 = 31'h7FFF_FFFF;

  localparam int SHIFTS_16 [15] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 12, 13, 14, 15, 16
  };

  localparam int SHIFTS_24 [23] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
    12, 13, 14, 15, 16, 17, 18, 19, 20, 21, 22
  };

  // 2^31 == 1 and 2^62 == 1 mod P, so fold the word in 31-bit slices.
  function automatic m31_t red64(input logic [63:0] v);
    logic [32:0] t;
    logic [31:0] u;
    logic [30:0] w;
    t = 33'(v[30:0]) + 33'(v[61:31]) + 33'(v[63:62]);
    u = 32'(t[30:0]) + 32'(t[32:31]);
    w = u[30:0] + 31'(u[31]);
    return (w == P_M31) ? '0 : w;
  endfunction

  function automatic m31_t mulm(input m31_t a, input m31_t b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return red64(p);
  endfunction

endpackage

module m31_partial_round_seq
  import m31_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ROUNDS = 14,
  parameter int RC_AW  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  m31_t [WIDTH-1:0]       state_i,
  output logic [RC_AW-1:0]       rc_idx_o,
  input  m31_t                   rc_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output m31_t [WIDTH-1:0]       state_o
);

  localparam int LAT = 18;
  localparam int SB  = 15;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } st_t;

  st_t              st;
  logic [RC_AW-1:0] round;
  logic [4:0]       cnt;

  m31_t [WIDTH-1:0] cur;
  m31_t [WIDTH-1:0] pv [SB+1];
  m31_t             sx [1:2];
  m31_t [WIDTH-1:0] lv1;
  m31_t             ls1;
  m31_t [WIDTH-1:0] lout;

  m31_t             rc_sum;
  m31_t             lsum;
  m31_t             y [WIDTH];
  logic [63:0]      acc;

  logic accept;
  logic last;

  assign accept   = (st == IDLE) && in_valid_i && in_ready_o;
  assign last     = (st == RUN) && (cnt == 5'(LAT));
  assign rc_idx_o = round;

  assign rc_sum = red64(64'(cur[0]) + 64'(rc_i));

  always_ff @(posedge clk) begin
    if (accept) begin
      cur <= state_i;
    end else if (last) begin
      cur <= lout;
    end
  end

  // Free-running pipeline: only the sample taken while cnt == 0
  // is ever harvested, so stale contents are harmless.
  always_ff @(posedge clk) begin
    pv[0]    <= cur;
    pv[0][0] <= rc_sum;
    sx[1]    <= pv[0][0];
    sx[2]    <= sx[1];
    for (int k = 1; k <= SB; k++) begin
      pv[k] <= pv[k-1];
    end
    pv[1][0] <= mulm(pv[0][0], pv[0][0]);
    pv[2][0] <= mulm(pv[1][0], pv[1][0]);
    pv[3][0] <= mulm(pv[2][0], sx[2]);
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc = acc + 64'(pv[SB][i]);
    end
  end

  assign lsum = red64(acc);

  always_ff @(posedge clk) begin
    lv1 <= pv[SB];
    ls1 <= lsum;
  end

  assign y[0] = red64(64'(ls1) + (64'(P_M31 - lv1[0]) << 1));

  // Multiplying by 2^k mod P is a 31-bit rotate left by k.
  for (genvar i = 1; i < WIDTH; i++) begin : g_lane
    m31_t rot;
    if (WIDTH == 24) begin : g24
      assign rot = red64(64'(lv1[i]) << SHIFTS_24[i-1]);
    end else begin : g16
      assign rot = red64(64'(lv1[i]) << SHIFTS_16[i-1]);
    end
    assign y[i] = red64(64'(ls1) + 64'(rot));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      lout[i] <= y[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      round       <= '0;
      cnt         <= '0;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      state_o     <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (accept) begin
            in_ready_o <= 1'b0;
            round      <= '0;
            cnt        <= '0;
            st         <= RUN;
          end else begin
            in_ready_o <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == 5'(LAT)) begin
            cnt <= '0;
            if (round == RC_AW'(ROUNDS - 1)) begin
              state_o     <= lout;
              out_valid_o <= 1'b1;
              st          <= DONE;
            end else begin
              round <= round + 1'b1;
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            st          <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m31_partial_round_seq.sv
// tb_m31_partial_round_seq: three configurations of the round engine
// checked against a plain-arithmetic model of the round function.

module tb_m31_partial_round_seq;

  typedef longint vec_t [24];
  localparam longint P = 64'd2147483647;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] iv = '0;
  logic [2:0] ordy = '0;
  wire  [2:0] ir;
  wire  [2:0] ov;
  logic [16*31-1:0] si1 = '0;
  logic [16*31-1:0] si14 = '0;
  logic [24*31-1:0] si24 = '0;
  wire  [16*31-1:0] so1;
  wire  [16*31-1:0] so14;
  wire  [24*31-1:0] so24;
  wire  [4:0] ri1, ri14, ri24;
  wire  [30:0] rc1, rc14, rc24;
  longint rct [3][32];
  int nchk = 0;
  int nerr = 0;
  int idxlog [$];
  int sh16 [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 12, 13, 14, 15, 16};
  int sh24 [23] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
                    12, 13, 14, 15, 16, 17, 18, 19, 20, 21, 22};

  assign rc1  = 31'(rct[0][ri1]);
  assign rc14 = 31'(rct[1][ri14]);
  assign rc24 = 31'(rct[2][ri24]);

  m31_partial_round_seq #(.WIDTH(16), .ROUNDS(1), .RC_AW(5)) u_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
    .state_i(si1), .rc_idx_o(ri1), .rc_i(rc1), .out_valid_o(ov[0]),
    .out_ready_i(ordy[0]), .state_o(so1));

  m31_partial_round_seq #(.WIDTH(16), .ROUNDS(14), .RC_AW(5)) u_r14 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
    .state_i(si14), .rc_idx_o(ri14), .rc_i(rc14), .out_valid_o(ov[1]),
    .out_ready_i(ordy[1]), .state_o(so14));

  m31_partial_round_seq #(.WIDTH(24), .ROUNDS(21), .RC_AW(5)) u_w24 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
    .state_i(si24), .rc_idx_o(ri24), .rc_i(rc24), .out_valid_o(ov[2]),
    .out_ready_i(ordy[2]), .state_o(so24));

  always #5 clk = ~clk;

  function automatic int nwidth(input int sel);
    return (sel == 2) ? 24 : 16;
  endfunction

  function automatic int nrounds(input int sel);
    return (sel == 0) ? 1 : ((sel == 1) ? 14 : 21);
  endfunction

  function automatic longint pw5(input longint a);
    longint a2, a4;
    a2 = (a * a) % P;
    a4 = (a2 * a2) % P;
    return (a4 * a) % P;
  endfunction

  function automatic void model(input int sel, input vec_t st,
                                output vec_t o);
    vec_t x, y;
    longint s;
    int w, sh;
    w = nwidth(sel);
    x = st;
    for (int k = 0; k < nrounds(sel); k++) begin
      x[0] = pw5((x[0] + rct[sel][k]) % P);
      s = 0;
      for (int i = 0; i < w; i++) s = (s + x[i]) % P;
      y = '{default: 0};
      y[0] = (s + 2 * (P - x[0])) % P;
      for (int i = 1; i < w; i++) begin
        sh = (w == 24) ? sh24[i-1] : sh16[i-1];
        y[i] = (s + (x[i] * (longint'(1) << sh)) % P) % P;
      end
      x = y;
    end
    o = x;
  endfunction

  function automatic longint get_lane(input int sel, input int i);
    case (sel)
      0:       return longint'(so1[i*31 +: 31]);
      1:       return longint'(so14[i*31 +: 31]);
      default: return longint'(so24[i*31 +: 31]);
    endcase
  endfunction

  function automatic int get_idx(input int sel);
    case (sel)
      0:       return int'(ri1);
      1:       return int'(ri14);
      default: return int'(ri24);
    endcase
  endfunction

  function automatic vec_t rand_state(input int mode);
    vec_t v;
    v = '{default: 0};
    for (int i = 0; i < 24; i++) begin
      if (mode == 1) v[i] = P - 1;
      else if (mode == 2) v[i] = 0;
      else v[i] = longint'($urandom) % P;
    end
    return v;
  endfunction

  task automatic set_in(input int sel, input vec_t st);
    for (int i = 0; i < 24; i++) begin
      if (sel == 0 && i < 16) si1[i*31 +: 31] = 31'(st[i]);
      if (sel == 1 && i < 16) si14[i*31 +: 31] = 31'(st[i]);
      if (sel == 2) si24[i*31 +: 31] = 31'(st[i]);
    end
  endtask

  task automatic launch(input int sel, input vec_t st, output bit rdy);
    @(negedge clk);
    rdy = ir[sel];
    set_in(sel, st);
    iv[sel] = 1'b1;
    @(posedge clk);
    #1;
    iv[sel] = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int lat, output bit to);
    lat = 0;
    idxlog.delete();
    idxlog.push_back(get_idx(sel));
    while (!ov[sel] && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
      if (get_idx(sel) != idxlog[$]) idxlog.push_back(get_idx(sel));
    end
    to = !ov[sel];
  endtask

  task automatic read_out(input int sel, output vec_t o);
    o = '{default: 0};
    for (int i = 0; i < nwidth(sel); i++) o[i] = get_lane(sel, i);
  endtask

  task automatic finish_out(input int sel);
    @(negedge clk);
    ordy[sel] = 1'b1;
    @(posedge clk);
    #1;
    ordy[sel] = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    nchk++;
    if (ov !== 3'b000 || ir !== 3'b000) begin
      nerr++;
      $display("FAIL reset_flags: ov=%b ir=%b want 000 000", ov, ir);
    end
    nchk++;
    if (so1 !== '0 || so14 !== '0 || so24 !== '0) begin
      nerr++;
      $display("FAIL reset_state: state_o nonzero, want all zero");
    end
    nchk++;
    if (ri1 !== 5'd0 || ri14 !== 5'd0 || ri24 !== 5'd0) begin
      nerr++;
      $display("FAIL reset_idx: %0d %0d %0d want 0", ri1, ri14, ri24);
    end
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (ir !== 3'b000) begin
      nerr++;
      $display("FAIL reset_hold_ready: ir=%b want 000", ir);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nchk++;
    if (ir !== 3'b111) begin
      nerr++;
      $display("FAIL ready_rise: ir=%b want 111", ir);
    end
  endtask

  task automatic test_vectors();
    vec_t st, o;
    int lat;
    bit to, rdy;
    longint l0 [2] = '{1, 2};
    longint rcv [2] = '{0, 1};
    longint e0 [2] = '{2147483646, 2147483404};
    longint ei [2] = '{1, 243};
    for (int t = 0; t < 2; t++) begin
      st = '{default: 0};
      st[0] = l0[t];
      rct[0][0] = rcv[t];
      launch(0, st, rdy);
      nchk++;
      if (rdy !== 1'b1) begin
        nerr++;
        $display("FAIL vec%0d_ready: got %0d want 1", t, rdy);
      end
      wait_done(0, lat, to);
      nchk++;
      if (to || lat != 19) begin
        nerr++;
        $display("FAIL vec%0d_latency: got %0d want 19", t, lat);
      end
      read_out(0, o);
      nchk++;
      if (o[0] != e0[t]) begin
        nerr++;
        $display("FAIL vec%0d_lane0: got %0d want %0d", t, o[0], e0[t]);
      end
      for (int i = 1; i < 16; i++) begin
        nchk++;
        if (o[i] != ei[t]) begin
          nerr++;
          $display("FAIL vec%0d_lane%0d: got %0d want %0d",
                   t, i, o[i], ei[t]);
        end
      end
      finish_out(0);
      nchk++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
        nerr++;
        $display("FAIL vec%0d_handshake: ov=%b ir=%b want 0 1",
                 t, ov[0], ir[0]);
      end
    end
  endtask

  task automatic test_zero_r14();
    vec_t st, o;
    int lat;
    bit to, rdy;
    for (int k = 0; k < 32; k++) rct[1][k] = 0;
    st = rand_state(2);
    launch(1, st, rdy);
    wait_done(1, lat, to);
    nchk++;
    if (to || lat != 266) begin
      nerr++;
      $display("FAIL zero_latency: got %0d want 266", lat);
    end
    nchk++;
    if (idxlog.size() != 14) begin
      nerr++;
      $display("FAIL zero_idx_count: got %0d want 14", idxlog.size());
    end
    for (int k = 0; k < idxlog.size() && k < 14; k++) begin
      nchk++;
      if (idxlog[k] != k) begin
        nerr++;
        $display("FAIL zero_idx_step%0d: got %0d want %0d",
                 k, idxlog[k], k);
      end
    end
    read_out(1, o);
    for (int i = 0; i < 16; i++) begin
      nchk++;
      if (o[i] != 0) begin
        nerr++;
        $display("FAIL zero_lane%0d: got %0d want 0", i, o[i]);
      end
    end
    finish_out(1);
  endtask

  task automatic test_backpressure();
    vec_t st, o, e, h;
    int lat;
    bit to, rdy;
    for (int k = 0; k < 14; k++) rct[1][k] = longint'($urandom) % P;
    st = rand_state(0);
    model(1, st, e);
    launch(1, st, rdy);
    wait_done(1, lat, to);
    nchk++;
    if (to || lat != 266) begin
      nerr++;
      $display("FAIL bp_latency: got %0d want 266", lat);
    end
    read_out(1, o);
    for (int i = 0; i < 16; i++) begin
      nchk++;
      if (o[i] != e[i]) begin
        nerr++;
        $display("FAIL bp_lane%0d: got %0d want %0d", i, o[i], e[i]);
      end
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      read_out(1, h);
      nchk++;
      if (ov[1] !== 1'b1 || ir[1] !== 1'b0 || h != e) begin
        nerr++;
        $display("FAIL bp_hold_c%0d: ov=%b ir=%b want 1 0, stable state",
                 c, ov[1], ir[1]);
      end
    end
    finish_out(1);
    nchk++;
    if (ov[1] !== 1'b0 || ir[1] !== 1'b1) begin
      nerr++;
      $display("FAIL bp_handshake: ov=%b ir=%b want 0 1", ov[1], ir[1]);
    end
  endtask

  task automatic test_reset_midrun();
    vec_t st, o, e;
    int lat, n;
    bit to, rdy;
    st = rand_state(0);
    model(1, st, e);
    launch(1, st, rdy);
    n = 0;
    while (ri14 != 5'd5 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    nchk++;
    if (ri14 != 5'd5) begin
      nerr++;
      $display("FAIL mid_reach_round5: got %0d want 5", ri14);
    end
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if (ov[1] !== 1'b0 || ir[1] !== 1'b0 || so14 !== '0 || ri14 !== 5'd0) begin
      nerr++;
      $display("FAIL mid_reset_outputs: ov=%b ir=%b idx=%0d want 0 0 0",
               ov[1], ir[1], ri14);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nchk++;
    if (ir !== 3'b111) begin
      nerr++;
      $display("FAIL mid_ready_rise: ir=%b want 111", ir);
    end
    launch(1, st, rdy);
    wait_done(1, lat, to);
    nchk++;
    if (to || lat != 266) begin
      nerr++;
      $display("FAIL mid_latency: got %0d want 266", lat);
    end
    read_out(1, o);
    for (int i = 0; i < 16; i++) begin
      nchk++;
      if (o[i] != e[i]) begin
        nerr++;
        $display("FAIL mid_lane%0d: got %0d want %0d", i, o[i], e[i]);
      end
    end
    finish_out(1);
  endtask

  task automatic test_random_w24();
    vec_t st, o, e;
    int lat, hold;
    bit to, rdy;
    for (int k = 0; k < 21; k++) rct[2][k] = longint'($urandom) % P;
    rct[2][3] = P - 1;
    for (int n = 0; n < 40; n++) begin
      st = rand_state((n < 2) ? n + 1 : 0);
      model(2, st, e);
      launch(2, st, rdy);
      nchk++;
      if (rdy !== 1'b1) begin
        nerr++;
        $display("FAIL w24_ready_n%0d: got %0d want 1", n, rdy);
      end
      wait_done(2, lat, to);
      nchk++;
      if (to || lat != 399) begin
        nerr++;
        $display("FAIL w24_latency_n%0d: got %0d want 399", n, lat);
      end
      read_out(2, o);
      for (int i = 0; i < 24; i++) begin
        nchk++;
        if (o[i] != e[i] || o[i] >= P) begin
          nerr++;
          $display("FAIL w24_n%0d_lane%0d: got %0d want %0d",
                   n, i, o[i], e[i]);
        end
      end
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      finish_out(2);
      nchk++;
      if (ov[2] !== 1'b0) begin
        nerr++;
        $display("FAIL w24_release_n%0d: ov=%b want 0", n, ov[2]);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 32; k++) rct[s][k] = 0;
    test_reset();
    test_vectors();
    test_zero_r14();
    test_backpressure();
    test_reset_midrun();
    test_random_w24();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
